lsu_split: RTL and testbench



---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_extend.sv | 22 ++
 rtl/lsu_split.sv | 143 ++++++++++++++
 tb/tb_lsu_split.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: data-memory access types,
// FSM state encoding and alignment helpers.
package lsu_pkg;

  // DMType encoding, shared with the data memory and the control decoder.
  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT,
    ST_RESP
  } lsu_state_t;

  // Codes 101..111 have no meaning of their own and behave as a word access.
  function automatic logic is_word(input logic [2:0] t);
    return !(t inside {DM_HALF, DM_HALF_U, DM_BYTE, DM_BYTE_U});
  endfunction

  function automatic logic is_half(input logic [2:0] t);
    return (t == DM_HALF) || (t == DM_HALF_U);
  endfunction

  // Index of the last beat (number of beats minus one) for an access.
  function automatic logic [1:0] last_beat(input logic [2:0] t,
                                           input logic [1:0] addr_lo);
    if (is_word(t) && (addr_lo != 2'b00)) return 2'd3;
    if (is_half(t) && addr_lo[0])          return 2'd1;
    return 2'd0;
  endfunction

  // The memory only needs to know the width of a store, not its signedness.
  function automatic logic [2:0] store_norm(input logic [2:0] t);
    if (is_word(t)) return DM_WORD;
    if (is_half(t)) return DM_HALF;
    return DM_BYTE;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational sign/zero extender for reassembled split-load data.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  i_type,
  input  logic [31:0] i_raw,
  output logic [31:0] o_data
);

  // Select the valid low part of the raw value and extend it per the access type.
  always_comb begin
    // NOTE: every path assigns o_data (default arm included), so no latch is inferred.
    unique case (i_type)
      DM_HALF:   o_data = {{16{i_raw[15]}}, i_raw[15:0]};
      DM_HALF_U: o_data = {16'h0000, i_raw[15:0]};
      DM_BYTE:   o_data = {{24{i_raw[7]}}, i_raw[7:0]};
      DM_BYTE_U: o_data = {24'h000000, i_raw[7:0]};
      default:   o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/lsu_split.sv
// Load/store unit: issues aligned accesses as one memory beat and splits
// misaligned word/half accesses into little-endian byte beats.
module lsu_split
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [2:0]    req_type,
  output logic          req_ready,
  output logic          stall,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_split,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic [2:0]    dm_type,
  input  logic [DW-1:0] dm_rdata
);

  lsu_state_t    r_state;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [2:0]    r_type;
  logic          r_split;
  logic [1:0]    r_last_cnt;
  logic [1:0]    r_beat_cnt;
  logic [DW-1:0] r_asm;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_split;

  logic          w_last;
  logic [AW-1:0] w_beat_addr;
  logic [DW-1:0] w_asm_next;
  logic [DW-1:0] w_ext_data;
  logic [1:0]    w_req_last;

  assign w_last      = (r_beat_cnt == r_last_cnt);
  assign w_beat_addr = r_addr + AW'(r_beat_cnt);
  assign w_req_last  = last_beat(req_type, req_addr[1:0]);

  assign req_ready = (r_state == ST_IDLE);
  assign stall     = ((r_state == ST_IDLE) && req_valid) || (r_state == ST_BEAT);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_split = r_rsp_split;

  // Merge the byte returned in the current split beat into the assembly register.
  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{r_beat_cnt, 3'b000} +: 8] = dm_rdata[7:0];
  end

  lsu_extend u_extend (
    .i_type (r_type),
    .i_raw  (w_asm_next),
    .o_data (w_ext_data)
  );

  // Drive the memory port from the latched request; idle values outside BEAT.
  always_comb begin
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    dm_type  = DM_WORD;
    if (r_state == ST_BEAT) begin
      // The beat in a reset cycle must not reach memory, so rst gates the strobe directly.
      dm_we = r_we && !rst;
      if (r_split) begin
        dm_addr  = w_beat_addr;
        dm_wdata = r_wdata >> {r_beat_cnt, 3'b000};
        dm_type  = r_we ? DM_BYTE : DM_BYTE_U;
      end else begin
        dm_addr  = r_addr;
        dm_wdata = r_wdata;
        dm_type  = r_type;
      end
    end
  end

  // Access sequencer: latch request, step through beats, pulse the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_type      <= DM_WORD;
      r_split     <= 1'b0;
      r_last_cnt  <= 2'd0;
      r_beat_cnt  <= 2'd0;
      r_asm       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_split <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_split <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_type     <= req_we ? store_norm(req_type) : req_type;
            r_last_cnt <= w_req_last;
            r_split    <= (w_req_last != 2'd0);
            r_beat_cnt <= 2'd0;
            r_asm      <= '0;
            r_state    <= ST_BEAT;
          end
        end
        ST_BEAT: begin
          if (r_split && !r_we) r_asm <= w_asm_next;
          if (w_last) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_split <= r_split;
            if (r_we)         r_rsp_rdata <= '0;
            else if (r_split) r_rsp_rdata <= w_ext_data;
            else              r_rsp_rdata <= dm_rdata;
          end else begin
            r_beat_cnt <= r_beat_cnt + 2'd1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_split.sv
// Scoreboard bench for lsu_split: a byte-addressed memory model answers the
// memory port; expected beats and responses are queued at issue time and
// compared by independent monitors.
module tb_lsu_split;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_type;
  logic        req_ready;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_split;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_type;
  logic [31:0] dm_rdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  typ;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        split;
    int          cyc;
  } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] mem [256];

  lsu_split dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_type  (req_type),
    .req_ready (req_ready),
    .stall     (stall),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_split (rsp_split),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_type   (dm_type),
    .dm_rdata  (dm_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational read with extension, byte-lane writes on the edge.
  always_comb begin
    logic [7:0] a;
    a = dm_addr[7:0];
    case (dm_type)
      3'b001:  dm_rdata = {{16{mem[8'(a + 8'd1)][7]}}, mem[8'(a + 8'd1)], mem[a]};
      3'b010:  dm_rdata = {16'h0000, mem[8'(a + 8'd1)], mem[a]};
      3'b011:  dm_rdata = {{24{mem[a][7]}}, mem[a]};
      3'b100:  dm_rdata = {24'h000000, mem[a]};
      default: dm_rdata = {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
    endcase
  end

  always @(posedge clk) begin
    if (dm_we) begin
      case (dm_type)
        3'b001, 3'b010: begin
          mem[dm_addr[7:0]]              <= dm_wdata[7:0];
          mem[8'(dm_addr[7:0] + 8'd1)]   <= dm_wdata[15:8];
        end
        3'b011, 3'b100: mem[dm_addr[7:0]] <= dm_wdata[7:0];
        default: begin
          mem[dm_addr[7:0]]              <= dm_wdata[7:0];
          mem[8'(dm_addr[7:0] + 8'd1)]   <= dm_wdata[15:8];
          mem[8'(dm_addr[7:0] + 8'd2)]   <= dm_wdata[23:16];
          mem[8'(dm_addr[7:0] + 8'd3)]   <= dm_wdata[31:24];
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic push_beat(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] typ);
    beat_t b;
    b.we = we; b.addr = addr; b.wdata = wdata; b.typ = typ;
    beat_q.push_back(b);
  endtask

  task automatic push_rsp(input logic [31:0] rdata, input logic split, input int lat);
    rsp_t r;
    r.rdata = rdata; r.split = split; r.cyc = cyc + lat;
    rsp_q.push_back(r);
  endtask

  // Beat monitor: BEAT is the only state with req_ready low and stall high.
  always begin
    @(negedge clk);
    #1;
    if (!req_ready && stall) begin
      if (beat_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: addr 0x%08h with nothing queued", dm_addr);
      end else begin
        beat_t e;
        e = beat_q.pop_front();
        check("beat_we",    {31'd0, dm_we}, {31'd0, e.we});
        check("beat_addr",  dm_addr,        e.addr);
        check("beat_wdata", dm_wdata,       e.wdata);
        check("beat_type",  {29'd0, dm_type}, {29'd0, e.typ});
      end
    end
  end

  // Response monitor: compares data, split flag and arrival cycle.
  always begin
    @(negedge clk);
    #1;
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: rdata 0x%08h with nothing queued", rsp_rdata);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_split", {31'd0, rsp_split}, {31'd0, e.split});
        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Issue one request from IDLE; expected latency is counted from the accept cycle.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] typ, input logic [31:0] exp_rdata,
                       input logic exp_split, input int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_type = typ;
    #1;
    check("issue_ready", {31'd0, req_ready}, 32'd1);
    push_rsp(exp_rdata, exp_split, lat);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hDEAD_BEE0; req_wdata = 32'hFFFF_FFFF; req_type = 3'b001;
  endtask

  task automatic wait_done();
    int b = 0;
    while ((rsp_q.size() != 0 || beat_q.size() != 0) && b < 40) begin
      @(negedge clk);
      #2;
      b++;
    end
    if (b >= 40) check("drain_timeout", 32'(rsp_q.size() + beat_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hBB; mem[8'h11] = 8'hAA; mem[8'h12] = 8'h99; mem[8'h13] = 8'h88;
    mem[8'h03] = 8'hFE; mem[8'h04] = 8'h80; mem[8'h07] = 8'h85;
    mem[8'hFE] = 8'h5A; mem[8'hFF] = 8'h6B; mem[8'h00] = 8'h7C; mem[8'h01] = 8'h01;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_type = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready",    {31'd0, req_ready}, 32'd1);
    check("rst_stall",    {31'd0, stall},     32'd0);
    check("rst_rsp_vld",  {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_rdata,          32'd0);
    check("rst_dm_we",    {31'd0, dm_we},     32'd0);
    check("rst_dm_addr",  dm_addr,            32'd0);
    check("rst_dm_type",  {29'd0, dm_type},   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Aligned lw.
    push_beat(1'b0, 32'h10, 32'h0, 3'b000);
    issue(1'b0, 32'h10, 32'h0, 3'b000, 32'h8899AABB, 1'b0, 2);
    wait_done();

    // Split sw, then read back the two covering words.
    push_beat(1'b1, 32'h21, 32'h11223344, 3'b011);
    push_beat(1'b1, 32'h22, 32'h00112233, 3'b011);
    push_beat(1'b1, 32'h23, 32'h00001122, 3'b011);
    push_beat(1'b1, 32'h24, 32'h00000011, 3'b011);
    issue(1'b1, 32'h21, 32'h11223344, 3'b000, 32'h0, 1'b1, 5);
    wait_done();
    push_beat(1'b0, 32'h20, 32'h0, 3'b000);
    issue(1'b0, 32'h20, 32'h0, 3'b000, 32'h22334400, 1'b0, 2);
    wait_done();
    push_beat(1'b0, 32'h24, 32'h0, 3'b000);
    issue(1'b0, 32'h24, 32'h0, 3'b000, 32'h00000011, 1'b0, 2);
    wait_done();

    // Split lh / lhu at 0x03.
    push_beat(1'b0, 32'h03, 32'h0, 3'b100);
    push_beat(1'b0, 32'h04, 32'h0, 3'b100);
    issue(1'b0, 32'h03, 32'h0, 3'b001, 32'hFFFF80FE, 1'b1, 3);
    wait_done();
    push_beat(1'b0, 32'h03, 32'h0, 3'b100);
    push_beat(1'b0, 32'h04, 32'h0, 3'b100);
    issue(1'b0, 32'h03, 32'h0, 3'b010, 32'h000080FE, 1'b1, 3);
    wait_done();

    // Byte load at an odd address stays a single beat.
    push_beat(1'b0, 32'h07, 32'h0, 3'b011);
    issue(1'b0, 32'h07, 32'h0, 3'b011, 32'hFFFFFF85, 1'b0, 2);
    wait_done();

    // Aligned store with unsigned-half type goes out as signed-half type.
    push_beat(1'b1, 32'h30, 32'h0000BEEF, 3'b001);
    issue(1'b1, 32'h30, 32'h0000BEEF, 3'b010, 32'h0, 1'b0, 2);
    wait_done();
    push_beat(1'b0, 32'h30, 32'h0, 3'b000);
    issue(1'b0, 32'h30, 32'h0, 3'b000, 32'h0000BEEF, 1'b0, 2);
    wait_done();

    // Split word load wrapping past the top of the address space.
    push_beat(1'b0, 32'hFFFFFFFE, 32'h0, 3'b100);
    push_beat(1'b0, 32'hFFFFFFFF, 32'h0, 3'b100);
    push_beat(1'b0, 32'h00000000, 32'h0, 3'b100);
    push_beat(1'b0, 32'h00000001, 32'h0, 3'b100);
    issue(1'b0, 32'hFFFFFFFE, 32'h0, 3'b000, 32'h017C6B5A, 1'b1, 5);
    wait_done();

    // Back-to-back: req_valid held high, request changes during BEAT.
    push_beat(1'b0, 32'h10, 32'h0, 3'b000);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_type = 3'b000;
    #1;
    check("b2b_stall_idle", {31'd0, stall}, 32'd1);
    push_rsp(32'h8899AABB, 1'b0, 2);
    @(negedge clk);
    req_addr = 32'h07; req_type = 3'b011;
    #1;
    check("b2b_stall_beat", {31'd0, stall},     32'd1);
    check("b2b_ready_beat", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    #1;
    check("b2b_stall_resp", {31'd0, stall},     32'd0);
    check("b2b_ready_resp", {31'd0, req_ready}, 32'd0);
    check("b2b_dm_we_resp", {31'd0, dm_we},     32'd0);
    check("b2b_dm_addr_resp", dm_addr,          32'd0);
    @(negedge clk);
    #1;
    check("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
    check("b2b_stall_idle2", {31'd0, stall},    32'd1);
    push_beat(1'b0, 32'h07, 32'h0, 3'b011);
    push_rsp(32'hFFFFFF85, 1'b0, 2);
    @(negedge clk);
    req_valid = 1'b0;
    wait_done();

    // Reset during the second beat of a split sw at 0x01.
    push_beat(1'b1, 32'h01, 32'hAABBCCDD, 3'b011);
    push_beat(1'b0, 32'h02, 32'h00AABBCC, 3'b011);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h01; req_wdata = 32'hAABBCCDD; req_type = 3'b000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_ready",   {31'd0, req_ready}, 32'd1);
    check("rstmid_rsp_vld", {31'd0, rsp_valid}, 32'd0);
    check("rstmid_beats",   32'(beat_q.size()), 32'd0);
    push_beat(1'b0, 32'h00, 32'h0, 3'b000);
    issue(1'b0, 32'h00, 32'h0, 3'b000, 32'hFE00DD7C, 1'b0, 2);
    wait_done();

    repeat (3) @(negedge clk);
    check("rsp_q_empty",  32'(rsp_q.size()),  32'd0);
    check("beat_q_empty", 32'(beat_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
